// File: rtl/hack_cpu_pkg.sv
// hack_cpu_pkg
// Shared definitions for the multi-cycle Hack CPU: the control state
// encoding, the bit positions of the instruction fields and the ALU
// control bit positions inside the comp field.
// Ports: none (package).
package hack_cpu_pkg;

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        MREAD  = 3'd2,
        EXEC   = 3'd3,
        MWRITE = 3'd4
    } state_t;

    // Instruction word fields
    localparam int IR_CI   = 15;  // 1 = C-instruction, 0 = A-instruction
    localparam int IR_A    = 12;  // ALU y operand: 1 = M, 0 = A
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;

    // Destination bits
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;

    // Jump bits {lt, eq, gt}
    localparam int JMP_LT  = 2;
    localparam int JMP_EQ  = 1;
    localparam int JMP_GT  = 0;

    // Bit positions inside the 6-bit comp field
    localparam int ALU_ZX  = 5;
    localparam int ALU_NX  = 4;
    localparam int ALU_ZY  = 3;
    localparam int ALU_NY  = 2;
    localparam int ALU_F   = 1;
    localparam int ALU_NO  = 0;

endpackage

// File: rtl/hack_alu.sv
// hack_alu
// Purely combinational Hack ALU at DATA_W bits. Arithmetic wraps modulo
// 2^DATA_W; there is no carry out.
// Ports:
//   x, y  in  DATA_W  operands (x = D, y = A or M)
//   ctrl  in  6       comp field {zx, nx, zy, ny, f, no}
//   out   out DATA_W  result
//   zr    out 1       out == 0
//   ng    out 1       out is negative (MSB set)
module hack_alu
    import hack_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    input  logic        [5:0]        ctrl,
    output logic signed [DATA_W-1:0] out,
    output logic                     zr,
    output logic                     ng
);

    logic signed [DATA_W-1:0] x_z;
    logic signed [DATA_W-1:0] x_n;
    logic signed [DATA_W-1:0] y_z;
    logic signed [DATA_W-1:0] y_n;
    logic signed [DATA_W-1:0] f_out;

    always_comb begin
        x_z   = ctrl[ALU_ZX] ? '0 : x;
        x_n   = ctrl[ALU_NX] ? ~x_z : x_z;
        y_z   = ctrl[ALU_ZY] ? '0 : y;
        y_n   = ctrl[ALU_NY] ? ~y_z : y_z;
        f_out = ctrl[ALU_F]  ? (x_n + y_n) : (x_n & y_n);
        out   = ctrl[ALU_NO] ? ~f_out : f_out;
        zr    = (out == '0);
        ng    = out[DATA_W-1];
    end

endmodule

// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc
// Multi-cycle Hack CPU with req/ack instruction and data memory ports.
// State sequence: BOOT -> FETCH -> [MREAD] -> EXEC -> [MWRITE] -> FETCH.
// Optional feature: define HACK_CPU_INSTRET_EN to add a 32-bit retired
// instruction counter output (instret).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   imem_req/addr       instruction fetch request, address (= pc)
//   imem_rdata/ack      instruction word, fetch complete
//   dmem_req/we/addr    data access request, write enable, address (old A)
//   dmem_wdata          ALU result for writes
//   dmem_rdata/ack      read data, access complete
//   pc                  current program counter
//   instret             retired instruction count (HACK_CPU_INSTRET_EN only)
module hack_cpu_mc
    import hack_cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc
`ifdef HACK_CPU_INSTRET_EN
    ,
    output logic [31:0]       instret
`endif
);

    state_t                   state;
    logic        [15:0]       ir;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] d;
    logic signed [DATA_W-1:0] mdr;
    logic signed [DATA_W-1:0] wq;
    // Only the address bits of the pre-instruction A are ever used
    logic        [ADDR_W-1:0] aq;

    logic signed [DATA_W-1:0] alu_y;
    logic signed [DATA_W-1:0] alu_out;
    logic                     alu_zr;
    logic                     alu_ng;
    logic                     jump_take;
    logic        [ADDR_W-1:0] pc_next_seq;

    assign alu_y       = ir[IR_A] ? mdr : a;
    assign pc_next_seq = pc + ADDR_W'(1);
    assign jump_take   = (ir[JMP_LT] & alu_ng)
                       | (ir[JMP_EQ] & alu_zr)
                       | (ir[JMP_GT] & ~alu_zr & ~alu_ng);

    hack_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .x    (d),
        .y    (alu_y),
        .ctrl (ir[COMP_HI:COMP_LO]),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    // Memory-side outputs come straight from registers so they stay stable
    // for the whole handshake.
    assign imem_addr  = pc;
    assign dmem_addr  = aq;
    assign dmem_wdata = wq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            ir       <= '0;
            a        <= '0;
            d        <= '0;
            aq       <= '0;
            mdr      <= '0;
            wq       <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end

                FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        aq       <= a[ADDR_W-1:0];
                        imem_req <= 1'b0;
                        // Decode directly from the incoming word so the M read
                        // request is raised on the same edge the fetch ends.
                        if (imem_rdata[IR_CI] && imem_rdata[IR_A]) begin
                            state    <= MREAD;
                            dmem_req <= 1'b1;
                            dmem_we  <= 1'b0;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end

                MREAD: begin
                    if (dmem_ack) begin
                        mdr      <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= EXEC;
                    end
                end

                EXEC: begin
                    if (!ir[IR_CI]) begin
                        a        <= {{(DATA_W-15){1'b0}}, ir[14:0]};
                        pc       <= pc_next_seq;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        if (ir[DEST_A]) a <= alu_out;
                        if (ir[DEST_D]) d <= alu_out;
                        wq <= alu_out;
                        pc <= jump_take ? aq : pc_next_seq;
                        if (ir[DEST_M]) begin
                            state    <= MWRITE;
                            dmem_req <= 1'b1;
                            dmem_we  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end

                MWRITE: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end

                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HACK_CPU_INSTRET_EN
    logic retire;

    // An instruction retires in EXEC unless it still owes an M write, in
    // which case it retires when that write is acknowledged.
    assign retire = ((state == EXEC) && !(ir[IR_CI] && ir[DEST_M]))
                  || ((state == MWRITE) && dmem_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// tb_hack_cpu_mc
// Directed bench for hack_cpu_mc: a 16-bit core with a configurable
// wait-state data memory and a 32-bit core with zero-wait memories.
module tb_hack_cpu_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_w = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- 16-bit DUT and its memories ----------------
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [14:0] imem_addr, dmem_addr, pc;
    logic [15:0] imem_rdata, dmem_wdata, dmem_rdata;
`ifdef HACK_CPU_INSTRET_EN
    logic [31:0] instret;
`endif

    logic [15:0] imem [32];
    logic [15:0] dmem [128];
    int dwait = 0;
    int dcnt = 0;

    assign imem_rdata = imem[imem_addr[4:0]];
    assign imem_ack   = imem_req;
    assign dmem_rdata = dmem[dmem_addr[6:0]];
    assign dmem_ack   = dmem_req && (dcnt >= dwait);

    hack_cpu_mc #(.DATA_W(16), .ADDR_W(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .pc         (pc)
`ifdef HACK_CPU_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    // Logs of accepted fetches and writes, appended only here
    int          cyc = 0;
    int          fcnt = 0;
    int          wcnt = 0;
    logic [14:0] fa [256];
    int          fcyc [256];
    logic [14:0] wa [64];
    logic [15:0] wd [64];
    int          wcyc [64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
        else dcnt <= 0;
        if (imem_req && imem_ack) begin
            fa[fcnt & 255]   <= imem_addr;
            fcyc[fcnt & 255] <= cyc;
            fcnt <= fcnt + 1;
        end
        if (dmem_req && dmem_we && dmem_ack) begin
            wa[wcnt & 63]   <= dmem_addr;
            wd[wcnt & 63]   <= dmem_wdata;
            wcyc[wcnt & 63] <= cyc;
            wcnt <= wcnt + 1;
        end
    end

    // ---------------- 32-bit DUT and its memories ----------------
    logic        imem_req_w, imem_ack_w, dmem_req_w, dmem_we_w, dmem_ack_w;
    logic [14:0] imem_addr_w, dmem_addr_w, pc_w;
    logic [15:0] imem_rdata_w;
    logic [31:0] dmem_wdata_w, dmem_rdata_w;
`ifdef HACK_CPU_INSTRET_EN
    logic [31:0] instret_w;
`endif
    logic [15:0] imem_w [32];

    assign imem_rdata_w = imem_w[imem_addr_w[4:0]];
    assign imem_ack_w   = imem_req_w;
    assign dmem_rdata_w = 32'h0;
    assign dmem_ack_w   = dmem_req_w;

    hack_cpu_mc #(.DATA_W(32), .ADDR_W(15)) dut_w (
        .clk        (clk),
        .rst        (rst_w),
        .imem_req   (imem_req_w),
        .imem_addr  (imem_addr_w),
        .imem_rdata (imem_rdata_w),
        .imem_ack   (imem_ack_w),
        .dmem_req   (dmem_req_w),
        .dmem_we    (dmem_we_w),
        .dmem_addr  (dmem_addr_w),
        .dmem_wdata (dmem_wdata_w),
        .dmem_rdata (dmem_rdata_w),
        .dmem_ack   (dmem_ack_w),
        .pc         (pc_w)
`ifdef HACK_CPU_INSTRET_EN
        ,
        .instret    (instret_w)
`endif
    );

    int          fcnt_w = 0;
    int          wcnt_w = 0;
    logic [14:0] fa_w [16];
    logic [14:0] wa_w [16];
    logic [31:0] wd_w [16];

    always @(posedge clk) begin
        if (imem_req_w && imem_ack_w) begin
            fa_w[fcnt_w & 15] <= imem_addr_w;
            fcnt_w <= fcnt_w + 1;
        end
        if (dmem_req_w && dmem_we_w && dmem_ack_w) begin
            wa_w[wcnt_w & 15] <= dmem_addr_w;
            wd_w[wcnt_w & 15] <= dmem_wdata_w;
            wcnt_w <= wcnt_w + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic clr_imem;
        for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_fetch(input int target, input string tag);
        int k = 0;
        while (fcnt < target && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (fcnt < target) chk(tag, 64'd0, 64'd1);
    endtask

    task automatic wait_write(input int target, input string tag);
        int k = 0;
        while (wcnt < target && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (wcnt < target) chk(tag, 64'd0, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fb;
        int wb;
        int rc;
        int ab;
        int k;
        logic [14:0] jexp [5];

        for (int i = 0; i < 128; i++) dmem[i] = 16'h0000;
        for (int i = 0; i < 32; i++) imem_w[i] = 16'h0000;

        // ---- basic program, with reset values checked while rst is high ----
        clr_imem();
        imem[0] = 16'h0005;  // @5
        imem[1] = 16'hEC10;  // D=A
        imem[2] = 16'h0064;  // @100
        imem[3] = 16'hE308;  // M=D
        dwait = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_pc", pc, 15'd0);
        chk("rst_ireq", imem_req, 1'b0);
        chk("rst_dreq", dmem_req, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        fb = fcnt;
        wb = wcnt;
        wait_write(wb + 1, "basic_timeout");
        chk("basic_waddr", wa[wb & 63], 15'd100);
        chk("basic_wdata", wd[wb & 63], 16'd5);
        chk("basic_cycles", wcyc[wb & 63] - fcyc[fb & 255], 8);
`ifdef HACK_CPU_INSTRET_EN
        chk("basic_instret", instret, 32'd4);
`endif
        for (int i = 0; i < 4; i++) chk("basic_fetch_seq", fa[(fb + i) & 255], 15'(i));

        // ---- reset in the middle of a stalled M read ----
        clr_imem();
        imem[0] = 16'h0007;  // @7
        imem[1] = 16'hFC10;  // D=M
        dwait = 1000;
        do_reset();
        k = 0;
        while (!dmem_req && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_dreq_up", dmem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_dreq_drop", dmem_req, 1'b0);
        chk("mid_ireq", imem_req, 1'b0);
        chk("mid_pc", pc, 15'd0);
        @(negedge clk);
        dwait = 0;
        rst = 1'b0;
        #1;
        chk("boot_ireq_low", imem_req, 1'b0);
        @(posedge clk); #1;
        chk("boot_fetch_req", imem_req, 1'b1);
        chk("boot_fetch_addr", imem_addr, 15'd0);

        // ---- wait states on an M read ----
        clr_imem();
        imem[0] = 16'h0007;  // @7
        imem[1] = 16'hFC10;  // D=M
        imem[2] = 16'h0032;  // @50
        imem[3] = 16'hE308;  // M=D
        dmem[7] = 16'h1234;
        dwait = 3;
        do_reset();
        wb = wcnt;
        rc = 0;
        ab = 0;
        k = 0;
        while (wcnt == wb && k < 100) begin
            @(posedge clk); #1;
            if (dmem_req && !dmem_we) begin
                rc++;
                if (dmem_addr != 15'd7) ab++;
            end
            k++;
        end
        if (wcnt == wb) chk("wait_timeout", 64'd0, 64'd1);
        chk("wait_read_cycles", rc, 4);
        chk("wait_addr_stable", ab, 0);
        chk("wait_waddr", wa[wb & 63], 15'd50);
        chk("wait_d_value", wd[wb & 63], 16'h1234);
        dwait = 0;

        // ---- conditional jumps on D = -1 ----
        clr_imem();
        imem[0] = 16'hEE90;  // D=-1
        imem[1] = 16'h0014;  // @20
        imem[2] = 16'hE301;  // D;JGT (not taken)
        imem[3] = 16'hE304;  // D;JLT (taken)
        jexp[0] = 15'd0; jexp[1] = 15'd1; jexp[2] = 15'd2; jexp[3] = 15'd3; jexp[4] = 15'd20;
        do_reset();
        fb = fcnt;
        wait_fetch(fb + 5, "jump_timeout");
        for (int i = 0; i < 5; i++) chk("jump_fetch_seq", fa[(fb + i) & 255], jexp[i]);

        // ---- old-A semantics for AM=M+1 ----
        clr_imem();
        imem[0] = 16'h000A;  // @10
        imem[1] = 16'hFDE8;  // AM=M+1
        imem[2] = 16'hEA88;  // M=0 (address = new A)
        dmem[10] = 16'd41;
        do_reset();
        wb = wcnt;
        wait_write(wb + 2, "olda_timeout");
        chk("olda_waddr", wa[wb & 63], 15'd10);
        chk("olda_wdata", wd[wb & 63], 16'd42);
        chk("olda_new_a", wa[(wb + 1) & 63], 15'd42);
        chk("olda_zero", wd[(wb + 1) & 63], 16'd0);

        // ---- 32-bit datapath ----
        imem_w[0]  = 16'hEE90;  // D=-1
        imem_w[1]  = 16'h0005;  // @5
        imem_w[2]  = 16'hE308;  // M=D
        imem_w[3]  = 16'h7FFF;  // @0x7FFF
        imem_w[4]  = 16'hEA87;  // 0;JMP
        imem_w[31] = 16'h0000;  // @0 at 0x7FFF
        @(negedge clk);
        rst_w = 1'b0;
        k = 0;
        while (fcnt_w < 7 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (fcnt_w < 7) chk("wide_timeout", 64'd0, 64'd1);
        chk("wide_waddr", wa_w[0], 15'd5);
        chk("wide_d_neg1", wd_w[0], 32'hFFFF_FFFF);
        chk("wide_jmp_pc", fa_w[5], 15'h7FFF);
        chk("wide_pc_wrap", fa_w[6], 15'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
